ctrl_decode_queue: RTL
======================

// Module: ctrl_decode_queue
// PURPOSE
//  Per-core decode stage for the MultiCore pipeline: a DEPTH-entry instruction queue between fetch and
//  execute, with the control decoder on the queue head. Emits the full control word (jump/regdst/alusrc/
//  aluop/mem/atomic/halt/care-rt) with a valid/ready handshake. Tracks halt stickily so no instruction
//  younger than HALT is ever issued. One instance per core.
// PARAMETERS
//  DEPTH  4   queue entries; power of two, >=2
//  IW     32  instruction and PC width
// PORTS
//  CLK        in   1    clock, rising edge
//  nRST       in   1    asynchronous reset, active low
//  flush      in   1    discard all queued entries (branch/jump redirect)
//  in_valid   in   1    fetch offers in_instr/in_pc
//  in_ready   out  1    queue accepts this cycle
//  in_instr   in   IW   instruction word
//  in_pc      in   IW   PC of in_instr
//  out_valid  out  1    head entry valid; control outputs meaningful
//  out_ready  in   1    execute consumes head this cycle
//  out_instr  out  IW   head instruction
//  out_pc     out  IW   head PC
//  out_ctrl   out  ctrl_word_t  decoded control word of head (see STRUCTURE)
//  halted     out  1    HALT has been issued; sticky until reset
//  count      out  $clog2(DEPTH+1)  occupied entries
// BEHAVIOUR
//  Reset (nRST=0, async): wr/rd ptrs=0, count=0, out_valid=0, in_ready=1, halt_seen=0, halted=0,
//   out_instr/out_pc=0, out_ctrl=all-zero (aluop=ALU_SLL).
//  Push when in_valid&in_ready; pop when out_valid&out_ready; both in one cycle -> count unchanged.
//  in_ready = (count<DEPTH) & !halt_seen & !halted. Push at full is refused even with a pop that cycle.
//  Latency: entry written at edge N is visible at head (out_valid=1) after edge N; no combinational
//   in->out bypass, so an empty queue gives one-cycle latency.
//  Pointers wrap modulo DEPTH; count saturates at neither end (illegal states are unreachable).
//  Accepting a HALT word (32'hFFFFFFFF) sets halt_seen; no further push until flush or reset.
//  Popping the head with out_ctrl.halt=1 sets halted; halted blocks pushes permanently.
//  flush: next edge ptrs=0, count=0, halt_seen=0; an in_valid push in the same cycle is dropped;
//   a pop in the same cycle still completes (execute owns it). flush does not clear halted.
//  Decode per cpu_types_pkg opcodes: LL/SC -> atomic=1; SW/SC -> memwrite=1; JAL -> pctoreg=1,
//   regdst=2'd2; ADD/ADDI/SUB -> careof=1; R-type/branches/stores -> care_rt=1; unknown opcode ->
//   all-zero control word (NOP) with out_valid unaffected.
//  out_ctrl is zero whenever out_valid=0.
// CONFIGURATION
//  CTRL_PREDECODE_EN defined: decoder sits on the write side; ctrl_word_t is stored per entry and
//   out_ctrl comes straight from storage flops (shorter head path, DEPTH*|ctrl_word_t| extra flops).
//  Undefined: only instr/pc stored; decoder is combinational from the head entry.
//  Cycle-level port behaviour identical in both builds.
// STRUCTURE
//  cpu_types_pkg gains: typedef struct packed ctrl_word_t {jump_t[2:0], regdst_t[1:0], regwen,
//   alusrc_t[2:0], aluop_t aluop, memtoreg, pctoreg, memwrite, careof, atomic, halt, care_rt};
//   localparam HALT_WORD = 32'hFFFFFFFF.
//  Sub-module control_decoder: pure combinational instr -> ctrl_word_t, instantiated once,
//   placed on write or read side per CTRL_PREDECODE_EN. Queue storage/pointers stay in this module.
// TESTING
//  1 Reset mid-stream with count=3 -> same cycle out_valid=0, count=0, in_ready=1, halted=0.
//  2 Push ADDI,LW,SW,J with out_ready=0 -> count=4, in_ready=0; pop one -> in_ready=1 next cycle.
//  3 Push SC at empty queue -> out_valid next cycle, out_ctrl.atomic=1, memwrite=1, care_rt=1.
//  4 Push HALT then ADD offered -> ADD refused; pop HALT -> halted=1; flush -> halted stays 1.
//  5 Full queue, flush+pop+in_valid same cycle -> pop completes, push dropped, count=0 next cycle.
//  6 Push/pop every cycle for 3*DEPTH words -> pointer wrap, in-order PCs, count steady at 1.
//  Run all in both CTRL_PREDECODE_EN builds; port traces must match cycle for cycle.

Source files
------------

// File: rtl/ctrl_decode_queue_pkg.sv
// Shared types for the per-core decode queue: opcode/funct encodings, control-word fields
// and the HALT instruction word.
package ctrl_decode_queue_pkg;

    localparam logic [31:0] HALT_WORD = 32'hFFFFFFFF;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_JAL   = 6'b000011,
        OP_BEQ   = 6'b000100,
        OP_BNE   = 6'b000101,
        OP_ADDI  = 6'b001000,
        OP_ADDIU = 6'b001001,
        OP_SLTI  = 6'b001010,
        OP_SLTIU = 6'b001011,
        OP_ANDI  = 6'b001100,
        OP_ORI   = 6'b001101,
        OP_XORI  = 6'b001110,
        OP_LUI   = 6'b001111,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011,
        OP_LL    = 6'b110000,
        OP_SC    = 6'b111000,
        OP_HALT  = 6'b111111
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL  = 6'b000000,
        FN_SRL  = 6'b000010,
        FN_JR   = 6'b001000,
        FN_ADD  = 6'b100000,
        FN_ADDU = 6'b100001,
        FN_SUB  = 6'b100010,
        FN_SUBU = 6'b100011,
        FN_AND  = 6'b100100,
        FN_OR   = 6'b100101,
        FN_XOR  = 6'b100110,
        FN_NOR  = 6'b100111,
        FN_SLT  = 6'b101010,
        FN_SLTU = 6'b101011
    } funct_t;

    typedef enum logic [2:0] {NO_JUMP, JUMP, JUMP_REG, BR_EQ, BR_NE} jump_t;
    typedef enum logic [1:0] {RD_RT, RD_RD, RD_RA} regdst_t;
    typedef enum logic [2:0] {SRC_RT, SRC_SIGN, SRC_ZERO, SRC_LUI, SRC_SHAMT} alusrc_t;
    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
    } aluop_t;

    typedef struct packed {
        jump_t   jump;
        regdst_t regdst;
        logic    regwen;
        alusrc_t alusrc;
        aluop_t  aluop;
        logic    memtoreg;
        logic    pctoreg;
        logic    memwrite;
        logic    careof;
        logic    atomic;
        logic    halt;
        logic    care_rt;
    } ctrl_word_t;

    function automatic logic is_halt_word(input logic [31:0] w);
        return w == HALT_WORD;
    endfunction

endpackage

// File: rtl/ctrl_decode_queue_control_decoder.sv
// Purely combinational instruction -> control word decoder. Unknown opcodes and unknown
// R-type functs decode to the all-zero (NOP) control word.
module control_decoder
    import ctrl_decode_queue_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_word_t  ctrl_o
);

    opcode_t opcode;
    funct_t  funct;

    assign opcode = opcode_t'(instr_i[31:26]);
    assign funct  = funct_t'(instr_i[5:0]);

    always_comb begin
        ctrl_o = '0;
        case (opcode)
            OP_RTYPE: begin
                ctrl_o.regwen  = 1'b1;
                ctrl_o.regdst  = RD_RD;
                ctrl_o.care_rt = 1'b1;
                case (funct)
                    FN_SLL:  begin ctrl_o.aluop = ALU_SLL; ctrl_o.alusrc = SRC_SHAMT; end
                    FN_SRL:  begin ctrl_o.aluop = ALU_SRL; ctrl_o.alusrc = SRC_SHAMT; end
                    FN_JR:   begin
                        ctrl_o.jump   = JUMP_REG;
                        ctrl_o.regwen = 1'b0;
                        ctrl_o.regdst = RD_RT;
                    end
                    FN_ADD:  begin ctrl_o.aluop = ALU_ADD; ctrl_o.careof = 1'b1; end
                    FN_ADDU: ctrl_o.aluop = ALU_ADD;
                    FN_SUB:  begin ctrl_o.aluop = ALU_SUB; ctrl_o.careof = 1'b1; end
                    FN_SUBU: ctrl_o.aluop = ALU_SUB;
                    FN_AND:  ctrl_o.aluop = ALU_AND;
                    FN_OR:   ctrl_o.aluop = ALU_OR;
                    FN_XOR:  ctrl_o.aluop = ALU_XOR;
                    FN_NOR:  ctrl_o.aluop = ALU_NOR;
                    FN_SLT:  ctrl_o.aluop = ALU_SLT;
                    FN_SLTU: ctrl_o.aluop = ALU_SLTU;
                    default: ctrl_o = '0;
                endcase
            end
            OP_J:   ctrl_o.jump = JUMP;
            OP_JAL: begin
                ctrl_o.jump    = JUMP;
                ctrl_o.pctoreg = 1'b1;
                ctrl_o.regdst  = RD_RA;
                ctrl_o.regwen  = 1'b1;
            end
            OP_BEQ: begin ctrl_o.jump = BR_EQ; ctrl_o.aluop = ALU_SUB; ctrl_o.care_rt = 1'b1; end
            OP_BNE: begin ctrl_o.jump = BR_NE; ctrl_o.aluop = ALU_SUB; ctrl_o.care_rt = 1'b1; end
            OP_ADDI: begin
                ctrl_o.regwen = 1'b1; ctrl_o.alusrc = SRC_SIGN;
                ctrl_o.aluop  = ALU_ADD; ctrl_o.careof = 1'b1;
            end
            OP_ADDIU: begin ctrl_o.regwen = 1'b1; ctrl_o.alusrc = SRC_SIGN; ctrl_o.aluop = ALU_ADD;  end
            OP_SLTI:  begin ctrl_o.regwen = 1'b1; ctrl_o.alusrc = SRC_SIGN; ctrl_o.aluop = ALU_SLT;  end
            OP_SLTIU: begin ctrl_o.regwen = 1'b1; ctrl_o.alusrc = SRC_SIGN; ctrl_o.aluop = ALU_SLTU; end
            OP_ANDI:  begin ctrl_o.regwen = 1'b1; ctrl_o.alusrc = SRC_ZERO; ctrl_o.aluop = ALU_AND;  end
            OP_ORI:   begin ctrl_o.regwen = 1'b1; ctrl_o.alusrc = SRC_ZERO; ctrl_o.aluop = ALU_OR;   end
            OP_XORI:  begin ctrl_o.regwen = 1'b1; ctrl_o.alusrc = SRC_ZERO; ctrl_o.aluop = ALU_XOR;  end
            OP_LUI:   begin ctrl_o.regwen = 1'b1; ctrl_o.alusrc = SRC_LUI;  ctrl_o.aluop = ALU_OR;   end
            OP_LW, OP_LL: begin
                ctrl_o.regwen   = 1'b1;
                ctrl_o.memtoreg = 1'b1;
                ctrl_o.alusrc   = SRC_SIGN;
                ctrl_o.aluop    = ALU_ADD;
                ctrl_o.atomic   = (opcode == OP_LL);
            end
            OP_SW: begin
                ctrl_o.memwrite = 1'b1; ctrl_o.alusrc = SRC_SIGN;
                ctrl_o.aluop    = ALU_ADD; ctrl_o.care_rt = 1'b1;
            end
            // SC both stores rt and writes the success flag back into rt.
            OP_SC: begin
                ctrl_o.memwrite = 1'b1; ctrl_o.atomic   = 1'b1;
                ctrl_o.regwen   = 1'b1; ctrl_o.memtoreg = 1'b1;
                ctrl_o.alusrc   = SRC_SIGN; ctrl_o.aluop = ALU_ADD;
                ctrl_o.care_rt  = 1'b1;
            end
            OP_HALT: ctrl_o.halt = is_halt_word(instr_i);
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/ctrl_decode_queue.sv
// Per-core decode queue with control decoder on the head entry and sticky HALT tracking.
// CTRL_PREDECODE_EN moves the decoder to the write side and stores control words per entry.
module ctrl_decode_queue
    import ctrl_decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IW    = 32
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IW-1:0]              in_instr,
    input  logic [IW-1:0]              in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [IW-1:0]              out_instr,
    output logic [IW-1:0]              out_pc,
    output ctrl_word_t                 out_ctrl,
    output logic                       halted,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          halt_seen_q, halt_seen_d;
    logic          halted_q, halted_d;
    logic          push, pop, head_valid;
    ctrl_word_t    head_ctrl;

    logic [IW-1:0] instr_mem [DEPTH];
    logic [IW-1:0] pc_mem    [DEPTH];

    assign head_valid = (count_q != '0);
    assign in_ready   = (count_q < FULL_C) && !halt_seen_q && !halted_q;
    assign push       = in_valid && in_ready && !flush;
    assign pop        = head_valid && out_ready;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        halt_seen_d = halt_seen_q;
        halted_d    = halted_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            halt_seen_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                if (is_halt_word(in_instr[31:0]))
                    halt_seen_d = 1'b1;
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)
                count_d = count_q + CW'(1);
            else if (pop && !push)
                count_d = count_q - CW'(1);
        end
        // A popped HALT has reached execute, so it counts even under flush.
        if (pop && head_ctrl.halt)
            halted_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            halt_seen_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            halt_seen_q <= halt_seen_d;
            halted_q    <= halted_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= in_instr;
            pc_mem[wr_ptr_q]    <= in_pc;
        end
    end

`ifdef CTRL_PREDECODE_EN
    ctrl_word_t ctrl_mem [DEPTH];
    ctrl_word_t in_ctrl;

    control_decoder u_decoder (
        .instr_i (in_instr[31:0]),
        .ctrl_o  (in_ctrl)
    );

    always_ff @(posedge CLK) begin
        if (push)
            ctrl_mem[wr_ptr_q] <= in_ctrl;
    end

    assign head_ctrl = ctrl_mem[rd_ptr_q];
`else
    logic [IW-1:0] head_instr;

    assign head_instr = instr_mem[rd_ptr_q];

    control_decoder u_decoder (
        .instr_i (head_instr[31:0]),
        .ctrl_o  (head_ctrl)
    );
`endif

    // Storage is not reset, so every head-facing output is gated by occupancy.
    assign out_valid = head_valid;
    assign out_instr = head_valid ? instr_mem[rd_ptr_q] : '0;
    assign out_pc    = head_valid ? pc_mem[rd_ptr_q]    : '0;
    assign out_ctrl  = head_valid ? head_ctrl           : '0;
    assign halted    = halted_q;
    assign count     = count_q;

endmodule
